bht_param: RTL

- Parametrised successor to the branch history table in the RV32IMC pipeline.
- Direct-mapped table of 2^IDX_W entries. Each entry holds valid, tag, predicted branch target and a 2-bit saturating counter.
- IF: combinational lookup gives the taken prediction and target.
- ID: allocates entries for newly decoded branches/jumps. Internal IF→ID→EXE registers carry the prediction and index down the pipeline.
- EXE: resolves against actual outcome; updates counters and raises correction/flush with the correct next PC.

---
 rtl/bht_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/bht_param.sv
// Direct-mapped branch history table with IF lookup, ID allocation and EXE resolution.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_param #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [PC_W-1:0] if_PC,
  input  logic            stall,
  input  logic [PC_W-1:0] id_PC,
  input  logic [PC_W-1:0] id_branchtarget,
  input  logic            is_jump,
  input  logic            is_btype,
  input  logic [PC_W-1:0] exe_PC,
  input  logic [PC_W-1:0] exe_PCseq,
  input  logic [PC_W-1:0] exe_target,
  input  logic            exe_is_branch,
  input  logic            exe_feedback,
  output logic            if_prediction,
  output logic [PC_W-1:0] if_PBT,
  output logic [PC_W-1:0] exe_PBT,
  output logic            exe_correction,
  output logic            flush,
  output logic [PC_W-1:0] exe_CNI
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned TagW  = PC_W - IDX_W;

  // Table storage
  logic              valid_q [Depth];
  logic [TagW-1:0]   tag_q   [Depth];
  logic [PC_W-1:0]   tgt_q   [Depth];
  logic [1:0]        ctr_q   [Depth];

  // Pipe registers carrying the IF prediction down to EXE
  logic              id_pred_q, exe_pred_q;
  logic [PC_W-1:0]   id_pbt_q, exe_pbt_q;

  logic [IDX_W-1:0]  if_idx, id_idx, exe_idx;
  logic [TagW-1:0]   if_tag, id_tag, exe_tag;

  assign if_tag  = if_PC[PC_W-1:IDX_W];
  assign id_tag  = id_PC[PC_W-1:IDX_W];
  assign exe_tag = exe_PC[PC_W-1:IDX_W];

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] id_idx_q, exe_idx_q;

  assign if_idx  = if_PC[IDX_W-1:0] ^ ghr_q;
  assign id_idx  = id_idx_q;
  assign exe_idx = exe_idx_q;

  // History is only updated with resolved outcomes, so it never needs repair.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (exe_is_branch) begin
      ghr_q <= {ghr_q[IDX_W-2:0], exe_feedback};
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      id_idx_q  <= '0;
      exe_idx_q <= '0;
    end else if (flush) begin
      id_idx_q  <= '0;
      exe_idx_q <= '0;
    end else if (!stall) begin
      id_idx_q  <= if_idx;
      exe_idx_q <= id_idx_q;
    end
  end
`else
  assign if_idx  = if_PC[IDX_W-1:0];
  assign id_idx  = id_PC[IDX_W-1:0];
  assign exe_idx = exe_PC[IDX_W-1:0];
`endif

  // IF lookup
  logic if_hit;
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_prediction = if_hit & ctr_q[if_idx][1];
  assign if_PBT        = if_hit ? tgt_q[if_idx] : '0;

  // EXE resolution
  logic exe_upd;
  logic [1:0] ctr_cur, ctr_upd;

  assign exe_upd = exe_is_branch && valid_q[exe_idx] && (tag_q[exe_idx] == exe_tag);
  assign ctr_cur = ctr_q[exe_idx];

  always_comb begin
    ctr_upd = ctr_cur;
    if (exe_feedback) begin
      if (ctr_cur != 2'b11) ctr_upd = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_upd = ctr_cur - 2'b01;
    end
  end

  logic mispredict;
  assign mispredict = (exe_pred_q != exe_feedback) ||
                      (exe_pred_q && exe_feedback && (exe_pbt_q != exe_target));

  assign exe_correction = ~rst & exe_is_branch & mispredict;
  assign flush          = exe_correction;
  assign exe_CNI        = rst ? '0 : (exe_feedback ? exe_target : exe_PCseq);
  assign exe_PBT        = exe_pbt_q;

  // ID allocation / retarget; a same-index EXE update takes priority
  logic id_is_br, id_hit, id_alloc, id_retarget, id_wr;

  assign id_is_br    = is_jump | is_btype;
  assign id_hit      = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
  assign id_alloc    = id_is_br && !id_hit;
  assign id_retarget = id_is_br && id_hit && (tgt_q[id_idx] != id_branchtarget);
  assign id_wr       = (id_alloc || id_retarget) && !(exe_upd && (exe_idx == id_idx));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      if (id_wr) begin
        valid_q[id_idx] <= 1'b1;
        tag_q[id_idx]   <= id_tag;
        tgt_q[id_idx]   <= id_branchtarget;
        if (id_alloc) begin
          ctr_q[id_idx] <= is_jump ? 2'b11 : CTR_INIT;
        end
      end
      if (exe_upd) begin
        ctr_q[exe_idx] <= ctr_upd;
        if (exe_feedback) begin
          tgt_q[exe_idx] <= exe_target;
        end
      end
    end
  end

  // Flush overrides stall
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      id_pred_q  <= 1'b0;
      id_pbt_q   <= '0;
      exe_pred_q <= 1'b0;
      exe_pbt_q  <= '0;
    end else if (flush) begin
      id_pred_q  <= 1'b0;
      id_pbt_q   <= '0;
      exe_pred_q <= 1'b0;
      exe_pbt_q  <= '0;
    end else if (!stall) begin
      id_pred_q  <= if_prediction;
      id_pbt_q   <= if_PBT;
      exe_pred_q <= id_pred_q;
      exe_pbt_q  <= id_pbt_q;
    end
  end

endmodule
